// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - shared constants and scheduler state type for the MAP decoder datapath
package map_pkg;

  localparam int W    = 16;
  localparam int NREQ = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting just after the last grant
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW-1:0] j;

  // Scan last+1 .. last+N so the previous winner has lowest priority.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 1; k <= N; k++) begin
      j = IDW'((int'(last) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/adder_sched.sv
// rtl/adder_sched.sv - round-robin scheduler sharing one registered signed adder among requesters
module adder_sched #(
  parameter int NREQ = map_pkg::NREQ,
  parameter int W    = map_pkg::W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W-1:0]      add_s,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_ovf,
  input  logic              rsp_ready
);
  import map_pkg::*;

  sched_state_t   state;
  logic [IDW-1:0] last;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] idx;
  logic           any;
  logic           open;
  logic           take;

  rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
    .req  (req_valid),
    .last (last),
    .gnt  (gnt),
    .idx  (idx),
    .any  (any)
  );

  // A new request can be taken in IDLE, or in RESP when the current result is consumed.
  assign open      = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign req_ready = open ? gnt : '0;
  assign take      = open && any;

  assign rsp_sum = add_s;
  assign rsp_ovf = rsp_valid && (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      add_a     <= '0;
      add_b     <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) state <= EXEC;
        end
        EXEC: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= take ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (take) begin
        add_a  <= req_a[int'(idx)*W +: W];
        add_b  <= req_b[int'(idx)*W +: W];
        rsp_id <= idx;
        last   <= idx;
      end
    end
  end

endmodule

// File: tb/tb_adder_sched.sv
// tb/tb_adder_sched.sv - scoreboard bench for adder_sched with directed and random traffic
module tb_adder_sched;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;
  localparam int SMAX = (2 ** (W - 1)) - 1;
  localparam int SMIN = -(2 ** (W - 1));

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_s;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_ovf;
  logic              rsp_ready;

  always #5 clk = ~clk;

  adder_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf),
    .rsp_ready (rsp_ready)
  );

  // The shared adder that lives outside the scheduler.
  always_ff @(posedge clk) add_s <= add_a + add_b;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           ovf;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one transaction in flight, result visible two cycles after acceptance.
  bit   m_busy = 1'b0;
  int   m_age  = 0;
  int   m_last = NREQ - 1;
  int   last_acc = -1;

  logic [NREQ-1:0] vld = '0;
  logic [W-1:0]    opa[NREQ];
  logic [W-1:0]    opb[NREQ];
  bit              pend[NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_model(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic step(input logic rst, input logic rdy);
    int              win;
    int              full;
    bit              cur_rsp;
    bit              can_acc;
    logic [NREQ-1:0] exp_rdy;
    rsp_t            e;
    @(negedge clk);
    rst_n     = rst;
    rsp_ready = rdy;
    req_valid = vld;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
    #1;
    cur_rsp = m_busy && (m_age >= 2);
    can_acc = rst && (!m_busy || (cur_rsp && rdy));
    win     = rr_model(vld, m_last);
    exp_rdy = '0;
    if (can_acc && win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(cur_rsp));
    last_acc = -1;
    if (!rst) begin
      m_busy = 1'b0;
      m_last = NREQ - 1;
      exp_q.delete();
    end else if (can_acc && win >= 0) begin
      full  = int'($signed(opa[win])) + int'($signed(opb[win]));
      e.id  = win[IDW-1:0];
      e.sum = full[W-1:0];
      e.ovf = (full > SMAX) || (full < SMIN);
      exp_q.push_back(e);
      m_busy   = 1'b1;
      m_age    = 1;
      m_last   = win;
      last_acc = win;
    end else if (cur_rsp && rdy) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_age++;
    end
  endtask

  // Monitor: compares every presented result against the head of the expected queue.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d sum %0h expected no response", rsp_id, rsp_sum);
        end else begin
          e = exp_q[0];
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    vld = '0;
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i]  = W'(i + 1);
      opb[i]  = W'(i + 7);
      pend[i] = 1'b0;
    end

    // Reset state, with every requester asserting to prove req_ready stays low.
    vld = '1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("reset_add_a", 32'(add_a), 32'd0);
    check("reset_add_b", 32'(add_b), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
    vld = '0;
    step(1'b1, 1'b1);

    // Single requester 2: 100 + -30.
    opa[2] = 16'd100;
    opb[2] = -16'sd30;
    vld = 4'b0100;
    step(1'b1, 1'b1);
    idle_cycles(4);

    // All requesters continuously valid from reset: ids rotate 0,1,2,3,0,1.
    step(1'b0, 1'b1);
    vld = '1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1);
      if (last_acc >= 0) begin
        opa[last_acc] = rnd_op();
        opb[last_acc] = rnd_op();
      end
    end
    idle_cycles(3);

    // Overflow in both directions.
    opa[0] = 16'h7FFF;
    opb[0] = 16'h0001;
    vld = 4'b0001;
    step(1'b1, 1'b1);
    idle_cycles(3);
    opa[1] = 16'h8000;
    opb[1] = 16'hFFFF;
    vld = 4'b0010;
    step(1'b1, 1'b1);
    idle_cycles(3);

    // Back-pressure: hold the result five cycles with requesters 0 and 1 waiting.
    vld = 4'b0011;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    idle_cycles(3);

    // Reset during EXEC drops the transaction; afterwards 0 beats 3.
    step(1'b0, 1'b1);
    vld = 4'b0001;
    step(1'b1, 1'b1);
    vld = '0;
    step(1'b0, 1'b1);
    vld = 4'b1001;
    step(1'b1, 1'b1);
    idle_cycles(4);

    // Requester 1 withdraws while busy; requester 3 gets the next grant.
    vld = 4'b0001;
    step(1'b1, 1'b1);
    vld = 4'b1010;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    vld = 4'b1000;
    step(1'b1, 1'b1);
    idle_cycles(4);

    // Random traffic with random back-pressure and occasional withdrawals.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && last_acc == i) pend[i] = 1'b0;
        if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          opa[i]  = rnd_op();
          opb[i]  = rnd_op();
        end
        vld[i] = pend[i];
      end
      step(1'b1, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    idle_cycles(6);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
